// File: rtl/mem_pkg.sv
// Shared types and widths for the main-memory line arbiter and its line store.
package mem_pkg;

    localparam int unsigned LINE_W      = 128;
    localparam int unsigned LINE_ADDR_W = 20;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        RD,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_D,
        REQ_I
    } requester_t;

endpackage

// File: rtl/mem_line_array.sv
// Line store: MEM_LINES x LINE_W, one synchronous write port and one combinational read port.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int unsigned MEM_LINES = 1024,
    parameter int unsigned IDX_W     = $clog2(MEM_LINES)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    // Contents survive reset on purpose; there is no clear path.
    logic [LINE_W-1:0] mem_q [MEM_LINES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_line_arbiter.sv
// Arbitrates L1 D/I line fills and D write-backs onto a fixed-latency line store.
// Build option ARB_ROUND_ROBIN_EN: alternate the winner of contested requests instead of D-first.
module mem_line_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_LINES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reqD_mem,
    input  logic [LINE_ADDR_W-1:0] reqAddrD_mem,
    input  logic                   reqD_cache_write,
    input  logic [LINE_W-1:0]      data_to_mem,
    input  logic [LINE_ADDR_W-1:0] reqAddrD_write_mem,
    output logic [LINE_W-1:0]      data_from_mem,
    output logic                   read_ready_from_mem,
    output logic                   written_data_ack,
    input  logic                   reqI_mem,
    input  logic [LINE_ADDR_W-1:0] reqAddrI_mem,
    output logic [LINE_W-1:0]      data_to_icache,
    output logic                   read_ready_to_icache,
    output logic                   busy
);

    localparam int unsigned IDX_W = $clog2(MEM_LINES);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    arb_state_t        state_q, state_d;
    requester_t        grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [LINE_W-1:0] wr_data_q, wr_data_d;
    logic [LINE_W-1:0] dout_d_q, dout_d_d;
    logic [LINE_W-1:0] dout_i_q, dout_i_d;
    logic              rdy_d_q, rdy_d_d;
    logic              rdy_i_q, rdy_i_d;
    logic              ack_q, ack_d;
    logic              mem_we;
    logic [LINE_W-1:0] mem_rdata;
    logic              pick_i;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers only the winner of contested grants, so rounds of simultaneous requests alternate.
    requester_t last_win_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_win_q <= REQ_I;
        end else if (state_q == IDLE && reqD_mem && reqI_mem) begin
            last_win_q <= pick_i ? REQ_I : REQ_D;
        end
    end

    assign pick_i = reqI_mem && (!reqD_mem || last_win_q == REQ_D);
`else
    assign pick_i = reqI_mem && !reqD_mem;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        fill_idx_d = fill_idx_q;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        dout_d_d   = dout_d_q;
        dout_i_d   = dout_i_q;
        rdy_d_d    = 1'b0;
        rdy_i_d    = 1'b0;
        ack_d      = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (reqD_mem || reqI_mem) begin
                    cnt_d = CNT_LOAD;
                    if (pick_i) begin
                        grant_d    = REQ_I;
                        fill_idx_d = reqAddrI_mem[IDX_W-1:0];
                        state_d    = RD;
                    end else begin
                        grant_d    = REQ_D;
                        fill_idx_d = reqAddrD_mem[IDX_W-1:0];
                        wr_idx_d   = reqAddrD_write_mem[IDX_W-1:0];
                        wr_data_d  = data_to_mem;
                        state_d    = reqD_cache_write ? WB : RD;
                    end
                end
            end
            WB: begin
                if (cnt_q == '0) begin
                    mem_we  = 1'b1;
                    ack_d   = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = RD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    if (grant_q == REQ_D) begin
                        dout_d_d = mem_rdata;
                        rdy_d_d  = 1'b1;
                    end else begin
                        dout_i_d = mem_rdata;
                        rdy_i_d  = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= REQ_D;
            cnt_q      <= '0;
            fill_idx_q <= '0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            dout_d_q   <= '0;
            dout_i_q   <= '0;
            rdy_d_q    <= 1'b0;
            rdy_i_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            fill_idx_q <= fill_idx_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            dout_d_q   <= dout_d_d;
            dout_i_q   <= dout_i_d;
            rdy_d_q    <= rdy_d_d;
            rdy_i_q    <= rdy_i_d;
            ack_q      <= ack_d;
        end
    end

    // A reset landing on the commit edge must drop the write-back.
    mem_line_array #(
        .MEM_LINES (MEM_LINES),
        .IDX_W     (IDX_W)
    ) u_store (
        .clk     (clk),
        .we_i    (mem_we && !reset),
        .waddr_i (wr_idx_q),
        .wdata_i (wr_data_q),
        .raddr_i (fill_idx_q),
        .rdata_o (mem_rdata)
    );

    assign data_from_mem        = dout_d_q;
    assign data_to_icache       = dout_i_q;
    assign read_ready_from_mem  = rdy_d_q;
    assign read_ready_to_icache = rdy_i_q;
    assign written_data_ack     = ack_q;
    assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter against a line-level reference model.
module tb_mem_line_arbiter;

    localparam int unsigned LAT   = 4;
    localparam int unsigned LINES = 1024;
    localparam int unsigned IDX_W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         reqD_mem;
    logic [19:0]  reqAddrD_mem;
    logic         reqD_cache_write;
    logic [127:0] data_to_mem;
    logic [19:0]  reqAddrD_write_mem;
    logic [127:0] data_from_mem;
    logic         read_ready_from_mem;
    logic         written_data_ack;
    logic         reqI_mem;
    logic [19:0]  reqAddrI_mem;
    logic [127:0] data_to_icache;
    logic         read_ready_to_icache;
    logic         busy;

    mem_line_arbiter #(
        .LATENCY   (LAT),
        .MEM_LINES (LINES)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .reqD_mem             (reqD_mem),
        .reqAddrD_mem         (reqAddrD_mem),
        .reqD_cache_write     (reqD_cache_write),
        .data_to_mem          (data_to_mem),
        .reqAddrD_write_mem   (reqAddrD_write_mem),
        .data_from_mem        (data_from_mem),
        .read_ready_from_mem  (read_ready_from_mem),
        .written_data_ack     (written_data_ack),
        .reqI_mem             (reqI_mem),
        .reqAddrI_mem         (reqAddrI_mem),
        .data_to_icache       (data_to_icache),
        .read_ready_to_icache (read_ready_to_icache),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] model [LINES];
    int unsigned  written_q [$];
    logic [127:0] last_d;
    logic [127:0] last_i;
    bit           rr_prev_d;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [19:0] alias_addr(input int unsigned idx);
        logic [19:0] a;
        a = 20'($urandom);
        a[IDX_W-1:0] = idx[IDX_W-1:0];
        return a;
    endfunction

    // One request from a single requester; cycle k counts from the sampling edge.
    task automatic single(input bit use_d, input bit wr, input logic [19:0] waddr,
                          input logic [127:0] wdata, input logic [19:0] faddr);
        int           ack_cyc;
        int           rdy_cyc;
        logic [127:0] exp;
        if (wr) begin
            model[waddr[IDX_W-1:0]] = wdata;
            written_q.push_back(int'(waddr[IDX_W-1:0]));
        end
        exp     = model[faddr[IDX_W-1:0]];
        ack_cyc = wr ? LAT + 1 : -1;
        rdy_cyc = wr ? 2 * LAT + 1 : LAT + 1;
        @(posedge clk);
        #1;
        if (use_d) begin
            reqD_mem           = 1'b1;
            reqD_cache_write   = wr;
            reqAddrD_write_mem = waddr;
            data_to_mem        = wdata;
            reqAddrD_mem       = faddr;
        end else begin
            reqI_mem     = 1'b1;
            reqAddrI_mem = faddr;
        end
        @(posedge clk);
        #1;
        reqD_cache_write   = 1'($urandom);
        reqAddrD_write_mem = 20'($urandom);
        data_to_mem        = rand_line();
        reqAddrD_mem       = 20'($urandom);
        reqAddrI_mem       = 20'($urandom);
        for (int k = 1; k <= rdy_cyc + 2; k++) begin
            @(negedge clk);
            chk("ack", written_data_ack, k == ack_cyc);
            chk("ready_d", read_ready_from_mem, use_d && k == rdy_cyc);
            chk("ready_i", read_ready_to_icache, !use_d && k == rdy_cyc);
            chk("busy", busy, k <= rdy_cyc);
            chk("data_d", data_from_mem, (use_d && k >= rdy_cyc) ? exp : last_d);
            chk("data_i", data_to_icache, (!use_d && k >= rdy_cyc) ? exp : last_i);
            if (k == rdy_cyc) begin
                @(posedge clk);
                #1;
                reqD_mem = 1'b0;
                reqI_mem = 1'b0;
            end
        end
        if (use_d) last_d = exp;
        else last_i = exp;
    endtask

    // D and I fills raised in the same cycle.
    task automatic dual(input logic [19:0] daddr, input logic [19:0] iaddr);
        bit           d_first;
        int           w;
        int           l;
        int           rd;
        int           ri;
        logic [127:0] ed;
        logic [127:0] ei;
`ifdef ARB_ROUND_ROBIN_EN
        d_first   = !rr_prev_d;
        rr_prev_d = d_first;
`else
        d_first = 1'b1;
`endif
        w  = LAT + 1;
        l  = 2 * LAT + 3;
        rd = d_first ? w : l;
        ri = d_first ? l : w;
        ed = model[daddr[IDX_W-1:0]];
        ei = model[iaddr[IDX_W-1:0]];
        @(posedge clk);
        #1;
        reqD_mem         = 1'b1;
        reqD_cache_write = 1'b0;
        reqAddrD_mem     = daddr;
        reqI_mem         = 1'b1;
        reqAddrI_mem     = iaddr;
        @(posedge clk);
        for (int k = 1; k <= l + 2; k++) begin
            @(negedge clk);
            chk("dual_ack", written_data_ack, 1'b0);
            chk("dual_ready_d", read_ready_from_mem, k == rd);
            chk("dual_ready_i", read_ready_to_icache, k == ri);
            chk("dual_busy", busy, (k <= w) || (k >= w + 2 && k <= l));
            chk("dual_data_d", data_from_mem, (k >= rd) ? ed : last_d);
            chk("dual_data_i", data_to_icache, (k >= ri) ? ei : last_i);
            if (k == rd) begin
                @(posedge clk);
                #1;
                reqD_mem = 1'b0;
            end
            if (k == ri) begin
                @(posedge clk);
                #1;
                reqI_mem = 1'b0;
            end
        end
        last_d = ed;
        last_i = ei;
    endtask

    initial begin
        logic [127:0] pre7;
        logic [127:0] line_r;
        int unsigned  idx;
        int unsigned  op;

        reset              = 1'b1;
        reqD_mem           = 1'b0;
        reqAddrD_mem       = '0;
        reqD_cache_write   = 1'b0;
        data_to_mem        = '0;
        reqAddrD_write_mem = '0;
        reqI_mem           = 1'b0;
        reqAddrI_mem       = '0;
        last_d             = '0;
        last_i             = '0;
        rr_prev_d          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", written_data_ack, 1'b0);
        chk("rst_ready_d", read_ready_from_mem, 1'b0);
        chk("rst_ready_i", read_ready_to_icache, 1'b0);
        chk("rst_data_d", data_from_mem, 128'h0);
        chk("rst_data_i", data_to_icache, 128'h0);

        // Write-back then fill of the same line.
        single(1'b1, 1'b1, 20'h00005, {16{8'hA5}}, 20'h00005);

        // Contested fills: two rounds back to back.
        single(1'b1, 1'b1, 20'h00001, rand_line(), 20'h00001);
        single(1'b1, 1'b1, 20'h00002, rand_line(), 20'h00002);
        dual(20'h00001, 20'h00002);
        dual(20'h00001, 20'h00002);

        // Upper address bits alias onto the same line.
        line_r = rand_line();
        single(1'b1, 1'b1, 20'h00403, line_r, 20'h00403);
        single(1'b0, 1'b0, 20'h0, 128'h0, 20'h00003);

        // Reset in the middle of a write-back drops it.
        pre7 = rand_line();
        single(1'b1, 1'b1, 20'h00007, pre7, 20'h00007);
        @(posedge clk);
        #1;
        reqD_mem           = 1'b1;
        reqD_cache_write   = 1'b1;
        reqAddrD_write_mem = 20'h00007;
        data_to_mem        = ~pre7;
        reqAddrD_mem       = 20'h00007;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset            = 1'b0;
        reqD_mem         = 1'b0;
        reqD_cache_write = 1'b0;
        last_d           = '0;
        last_i           = '0;
        rr_prev_d        = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rstwb_ack", written_data_ack, 1'b0);
            chk("rstwb_ready_d", read_ready_from_mem, 1'b0);
            chk("rstwb_busy", busy, 1'b0);
            chk("rstwb_data_d", data_from_mem, 128'h0);
        end
        single(1'b1, 1'b0, 20'h0, 128'h0, 20'h00007);

        // Randomized mix against the reference model.
        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 3);
            unique case (op)
                0: begin
                    idx = $urandom_range(0, LINES - 1);
                    if ($urandom_range(0, 1) == 0) begin
                        single(1'b1, 1'b1, alias_addr(idx), rand_line(), alias_addr(idx));
                    end else begin
                        single(1'b1, 1'b1, alias_addr(idx), rand_line(),
                               alias_addr(written_q[$urandom_range(0, written_q.size() - 1)]));
                    end
                end
                1: single(1'b1, 1'b0, 20'h0, 128'h0,
                          alias_addr(written_q[$urandom_range(0, written_q.size() - 1)]));
                2: single(1'b0, 1'b0, 20'h0, 128'h0,
                          alias_addr(written_q[$urandom_range(0, written_q.size() - 1)]));
                default: dual(alias_addr(written_q[$urandom_range(0, written_q.size() - 1)]),
                              alias_addr(written_q[$urandom_range(0, written_q.size() - 1)]));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Main-memory side of the L1 caches. Sits directly downstream of the data cache and beside the instruction cache.
- Accepts 128-bit line fill requests from both caches and dirty-line write-backs from the data cache. Arbitrates between the two requesters.
- Services each request against an internal line store with a fixed, parameterised latency. Returns lines and acknowledgements with single-cycle pulses.

Parameters:
- LATENCY, 4: cycles from grant to completion of each memory access (read or write); must be >= 1.
- MEM_LINES, 1024: number of 128-bit lines in the store; power of two. Line index = line_addr[$clog2(MEM_LINES)-1:0].

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- reqD_mem  in  1  data-cache request (level, held until served)
- reqAddrD_mem  in  20  data-cache fill line address
- reqD_cache_write  in  1  request carries a dirty write-back first
- data_to_mem  in  128  write-back line
- reqAddrD_write_mem  in  20  write-back line address
- data_from_mem  out  128  fill line returned to data cache
- read_ready_from_mem  out  1  one-cycle pulse; data_from_mem valid in the same cycle
- written_data_ack  out  1  one-cycle pulse; write-back committed
- reqI_mem  in  1  instruction-cache request (level)
- reqAddrI_mem  in  20  instruction fill line address
- data_to_icache  out  128  fill line returned to instruction cache
- read_ready_to_icache  out  1  one-cycle pulse; data_to_icache valid in the same cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - all pulses 0, data outputs 128'b0, busy 0, state IDLE, latency counter 0.
  - The line store is not cleared.
- States and transitions:
  - IDLE:
    - Sample requests at the edge. The winner is granted; its addresses, data and write flag are latched.
    - D request with reqD_cache_write=1 -> WB. D request without it -> RD. I request -> RD.
    - Counter loads LATENCY-1.
  - WB:
    - Counter decrements each cycle.
    - At 0: commit the latched line to the latched write address, pulse written_data_ack for the next cycle, reload the counter, go to RD with the latched fill address.
  - RD:
    - Counter decrements. At 0: read the store and drive the line on the granted requester's data output with its ready pulse -> RESP.
  - RESP:
    - Single cooldown cycle; no grant is taken. The requester drops its request during this cycle. -> IDLE.
- Latency:
  - A plain fill's ready pulse is asserted LATENCY+1 cycles after the sampling edge.
  - Write-back plus fill: ack at LATENCY+1 cycles, ready at 2*LATENCY+1 cycles.
- Arbitration (default build): fixed priority, D over I. Simultaneous requests -> D served first; I is served on the next IDLE.
- Data outputs hold their last returned line until the next fill for the same requester.
- Read after write-back to the same line returns the new data (commit precedes the read).
- Inputs changing after grant are ignored. Requests are sampled only in IDLE.
- Address bits above the index are ignored (aliasing is allowed).
- Reset mid-operation:
  - Returns to IDLE next edge and clears all pulses.
  - An uncommitted write-back is dropped; the store is unmodified.

Optional Feature:
- ARB_ROUND_ROBIN_EN:
  - Defined: a last-served flag makes the opposite requester win simultaneous requests.
  - Not defined: fixed D-over-I priority as above.
  - Either way, a single pending request is granted immediately.

Decomposition:
- Package mem_pkg holds:
  - LINE_W=128 and LINE_ADDR_W=20
  - enum arb_state_t {IDLE, WB, RD, RESP}
  - enum requester_t {REQ_D, REQ_I}
- One sub-module, mem_line_array:
  - MEM_LINES x 128 storage, one synchronous write port, one combinational read port.
  - Keeps the arbiter FSM separate from the storage.

Test Plan:
- Write then fill, same line:
  - Stimulus: D request, write flag=1, write address 20'h00005, data 128'hA5A5...A5, fill address 20'h00005.
  - Response: ack pulse at cycle 5, ready at cycle 9 (LATENCY=4), data_from_mem=128'hA5A5...A5.
- Simultaneous requests, default build:
  - Stimulus: D and I fills issued together (D address 20'h00001, I address 20'h00002).
  - Response: D ready at cycle 5; I ready at cycle 11 after RESP and IDLE; busy high throughout except the IDLE cycle.
- Simultaneous requests, ARB_ROUND_ROBIN_EN defined: two back-to-back rounds of simultaneous D and I requests; the second round grants I first.
- Reset during WB:
  - Stimulus: assert reset in cycle 2 of a write-back to line 20'h00007, then read line 7.
  - Response: the read returns the pre-existing content; no ack is ever pulsed.
- Aliasing:
  - Stimulus: write-back to 20'h00403 with MEM_LINES=1024, then I fill of 20'h00003.
  - Response: the I fill returns the written line.
- Held request: D holds reqD_mem through RESP; exactly one ready pulse is issued per request.
